// File: rtl/ifu.sv
// Instruction fetch unit: fetches one instruction at a time, holds it until
// the downstream stage commits, then selects the next pc (jr/jal/beq/seq).
// Optional feature macro: IFU_ALIGN_CHK_EN -- halt on a misaligned next pc
// instead of silently clearing the low address bits.
module ifu (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    input  logic        nPC_Sel,
    input  logic        zero,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] rs_data,
    input  logic        commit,
    output logic        addr_exc
);

`ifdef IFU_ALIGN_CHK_EN
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1} state_t;
`endif

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, instr_nxt, target, br_off;
    logic        valid_nxt;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;

    // Branch offset: sign-extended word displacement from the held instruction.
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Next-pc select, priority jr > jal > taken beq > sequential.
    always_comb begin
        target = pc4;
        if (jr)
            target = rs_data;
        else if (jal)
            target = {pc4[31:28], instr[25:0], 2'b00};
        else if (nPC_Sel && zero)
            target = pc4 + br_off;
    end

`ifdef IFU_ALIGN_CHK_EN
    logic exc_q, exc_nxt;
    assign addr_exc = exc_q;
`else
    assign addr_exc = 1'b0;
`endif

    // Next-state and datapath update; control inputs only matter on commit in HOLD.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        imem_req  = 1'b0;
`ifdef IFU_ALIGN_CHK_EN
        exc_nxt   = exc_q;
`endif
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (commit) begin
                    valid_nxt = 1'b0;
`ifdef IFU_ALIGN_CHK_EN
                    if (target[1:0] != 2'b00) begin
                        exc_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end
`else
                    pc_nxt    = target & ~32'h3;
                    state_nxt = FETCH;
`endif
                end
            end
`ifdef IFU_ALIGN_CHK_EN
            HALT: begin
                state_nxt = HALT;
            end
`endif
            default: state_nxt = FETCH;
        endcase
    end

    // State and datapath registers; reset wins over any concurrent ack/commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
`ifdef IFU_ALIGN_CHK_EN
            exc_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
`ifdef IFU_ALIGN_CHK_EN
            exc_q       <= exc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: transaction-level model updated by the stimulus tasks,
// checked against the DUT on every falling edge, plus literal spot checks.
module tb_ifu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, instr_valid, addr_exc;
    logic [31:0] imem_addr, instr, pc, pc4;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        nPC_Sel = 1'b0, zero = 1'b0, jal = 1'b0, jr = 1'b0, commit = 1'b0;
    logic [31:0] rs_data = 32'h0;

    int n_pass = 0;
    int n_chk  = 0;

    // Model of the architecturally visible state.
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_fetch, m_halt, m_exc;
    logic        started = 1'b0;

    ifu dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc4(pc4),
        .nPC_Sel(nPC_Sel), .zero(zero), .jal(jal), .jr(jr),
        .rs_data(rs_data), .commit(commit), .addr_exc(addr_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    endtask

    // Next pc straight from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                               input logic s, input logic z, input logic jl,
                                               input logic j, input logic [31:0] rs);
        logic [31:0] seq, off;
        seq = cur_pc + 32'd4;
        off = 32'($signed(ins[15:0])) * 32'd4;
        if (j)           return rs;
        else if (jl)     return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
        else if (s && z) return seq + off;
        else             return seq;
    endfunction

    // Compare process: every falling edge once the model is initialised.
    always @(negedge clk) begin
        if (started) begin
            chk("imem_req", imem_req, m_fetch);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc4", pc4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("addr_exc", addr_exc, m_exc);
            if (!m_halt) chk("instr_valid", instr_valid, m_valid);
        end
    end

    task automatic model_reset();
        m_pc = 32'h3000; m_instr = 32'h0; m_valid = 0; m_fetch = 1; m_halt = 0; m_exc = 0;
    endtask

    // Reset optionally coincident with a live ack and/or commit.
    task automatic do_reset(input logic with_ack, input logic with_commit);
        @(posedge clk); #1;
        imem_ack = with_ack; imem_rdata = 32'hDEAD_BEEF;
        commit = with_commit; jr = with_commit; rs_data = 32'h0000_5000;
        reset = 1;
        model_reset();
        started = 1;
        @(posedge clk); #1;
        imem_ack = 0; commit = 0; jr = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    // Fetch with nwait ack-less cycles (stray commits during the wait).
    task automatic do_fetch(input logic [31:0] val, input int nwait);
        for (int i = 0; i < nwait; i++) begin
            imem_ack = 0; commit = i[0]; jr = 1; rs_data = 32'h0000_5000;
            @(posedge clk); #1;
        end
        commit = 0; jr = 0;
        imem_ack = 1; imem_rdata = val;
        @(posedge clk); #1;
        imem_ack = 0; imem_rdata = $urandom;
        m_instr = val; m_valid = 1; m_fetch = 0;
    endtask

    // Idle in HOLD with stray acks; nothing may move.
    task automatic do_hold(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1; imem_rdata = $urandom;
            nPC_Sel = 1; zero = 1; jr = 1; rs_data = $urandom;
            @(posedge clk); #1;
        end
        imem_ack = 0; nPC_Sel = 0; zero = 0; jr = 0;
    endtask

    task automatic do_commit(input logic s, input logic z, input logic jl, input logic j,
                             input logic [31:0] rs);
        logic [31:0] t;
        nPC_Sel = s; zero = z; jal = jl; jr = j; rs_data = rs; commit = 1;
        @(posedge clk); #1;
        commit = 0; nPC_Sel = 0; zero = 0; jal = 0; jr = 0; rs_data = $urandom;
        t = model_next(m_pc, m_instr, s, z, jl, j, rs);
        m_valid = 0;
`ifdef IFU_ALIGN_CHK_EN
        if (t % 4 != 0) begin
            m_exc = 1; m_halt = 1; m_fetch = 0;
        end else begin
            m_pc = t; m_fetch = 1;
        end
`else
        m_pc = t - (t % 4); m_fetch = 1;
`endif
    endtask

    initial begin
        do_reset(0, 0);
        chk("lit_reset_addr", imem_addr, 32'h0000_3000);
        chk("lit_reset_valid", instr_valid, 32'h0);
        do_fetch(32'h0000_0021, 0);
        chk("lit_first_instr", instr, 32'h0000_0021);
        chk("lit_first_valid", instr_valid, 32'h1);
        do_hold(3);

        // beq with offset -1 word, taken then not taken.
        do_reset(0, 0);
        do_fetch(32'h1000_FFFF, 0);
        do_commit(1, 1, 0, 0, 32'h0);
        chk("lit_beq_taken", imem_addr, 32'h0000_3000);
        do_fetch(32'h1000_FFFF, 1);
        do_commit(1, 0, 0, 0, 32'h0);
        chk("lit_beq_not_taken", imem_addr, 32'h0000_3004);

        // Long memory stall with stray commits, then sequential.
        do_fetch(32'h0000_0000, 5);
        do_commit(0, 0, 0, 0, 32'h0);
        chk("lit_seq", imem_addr, 32'h0000_3008);

        // jal, then jr beating jal.
        do_fetch(32'h0C00_0C10, 2);
        chk("lit_jal_pc4", pc4, 32'h0000_300C);
        do_commit(0, 0, 1, 0, 32'h0);
        chk("lit_jal_target", imem_addr, 32'h0000_3040);
        do_fetch(32'h0C00_0C10, 0);
        do_hold(2);
        do_commit(0, 0, 1, 1, 32'h0000_3100);
        chk("lit_jr_over_jal", imem_addr, 32'h0000_3100);

        // Forward taken branch, then wrap at the top of the address space.
        do_fetch(32'h1000_0010, 0);
        do_commit(1, 1, 0, 0, 32'h0);
        chk("lit_beq_fwd", imem_addr, 32'h0000_3144);
        do_fetch(32'h0, 0);
        do_commit(0, 0, 0, 1, 32'hFFFF_FFFC);
        do_fetch(32'h0, 0);
        do_commit(0, 0, 0, 0, 32'h0);
        chk("lit_wrap", imem_addr, 32'h0000_0000);

        // Reset with a pending ack in FETCH: nothing latched.
        do_reset(1, 0);
        chk("lit_rst_fetch_instr", instr, 32'h0);
        chk("lit_rst_fetch_addr", imem_addr, 32'h0000_3000);

        // Reset racing a commit in HOLD.
        do_fetch(32'h1234_5678, 0);
        do_reset(0, 1);
        chk("lit_rst_commit_addr", imem_addr, 32'h0000_3000);

        // Misaligned jr target.
        do_fetch(32'h0, 0);
        do_commit(0, 0, 0, 1, 32'h0000_3002);
`ifdef IFU_ALIGN_CHK_EN
        chk("lit_exc_flag", addr_exc, 32'h1);
        chk("lit_exc_req", imem_req, 32'h0);
        do_hold(3);
        commit = 1; @(posedge clk); #1; commit = 0;
        chk("lit_exc_stuck", imem_req, 32'h0);
        do_reset(0, 0);
        chk("lit_exc_cleared", addr_exc, 32'h0);
`else
        chk("lit_misalign_addr", imem_addr, 32'h0000_3000);
        chk("lit_misalign_exc", addr_exc, 32'h0);
`endif
        do_fetch(32'h0000_0021, 1);
        do_commit(0, 0, 0, 0, 32'h0);

        @(posedge clk); #1;
        started = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
